// File: rtl/fc_ctrl_pkg.sv
// Shared types and helpers for the fully-connected layer controller.
package fc_ctrl_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, OUTPUT} fc_state_t;

  // Bit width needed to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fc_layer_ctrl_mod_counter.sv
// Modulo-MOD counter with synchronous clear (priority) and count enable.
// wrap flags the terminal value so the caller can detect the last step.
module mod_counter
  import fc_ctrl_pkg::*;
#(
  parameter int MOD = 4,
  localparam int W = clog2_min1(MOD)
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = (cnt == W'(MOD - 1));

  // Clear wins over enable; counting past MOD-1 rolls back to zero.
  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (en)
      cnt <= wrap ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/fc_layer_ctrl.sv
// Sequencer for one fully-connected layer: load M inputs, then for each of
// N/P output groups run M accumulate steps on P MACs, let the MAC pipe
// drain, and stream P results out.
module fc_layer_ctrl
  import fc_ctrl_pkg::*;
#(
  parameter int M      = 4,
  parameter int N      = 8,
  parameter int P      = 2,
  parameter int MACLAT = 2,
  localparam int XW = clog2_min1(M),
  localparam int WW = clog2_min1(M * N / P),
  localparam int OW = clog2_min1(P)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          m_ready,
  output logic          m_valid,
  output logic          wr_en_x,
  output logic [XW-1:0] addr_x,
  output logic [WW-1:0] addr_w,
  output logic          clear_acc,
  output logic          en_acc,
  output logic [OW-1:0] out_sel
);

  localparam int G  = N / P;
  localparam int GW = clog2_min1(G);
  localparam int DW = clog2_min1(MACLAT);

  fc_state_t state, state_next;

  logic [XW-1:0] xcnt;
  logic [WW-1:0] wcnt;
  logic [GW-1:0] grp;
  logic [DW-1:0] dcnt;
  logic [OW-1:0] ocnt;

  logic x_en, x_clr, x_wrap;
  logic w_en, w_clr, w_wrap;
  logic g_en, g_clr, g_wrap;
  logic d_en, d_clr, d_wrap;
  logic o_en, o_clr, o_wrap;

  mod_counter #(.MOD(M))         u_xcnt (.clk(clk), .en(x_en), .clr(x_clr), .cnt(xcnt), .wrap(x_wrap));
  mod_counter #(.MOD(M * N / P)) u_wcnt (.clk(clk), .en(w_en), .clr(w_clr), .cnt(wcnt), .wrap(w_wrap));
  mod_counter #(.MOD(G))         u_grp  (.clk(clk), .en(g_en), .clr(g_clr), .cnt(grp),  .wrap(g_wrap));
  mod_counter #(.MOD(MACLAT))    u_dcnt (.clk(clk), .en(d_en), .clr(d_clr), .cnt(dcnt), .wrap(d_wrap));
  mod_counter #(.MOD(P))         u_ocnt (.clk(clk), .en(o_en), .clr(o_clr), .cnt(ocnt), .wrap(o_wrap));

  // Control only needs the terminal flags of these counters, not their values.
  logic unused_cnt;
  assign unused_cnt = &{1'b0, w_wrap, grp, dcnt};

  // State register; reset always lands in LOAD.
  always_ff @(posedge clk) begin
    if (!reset)
      state <= LOAD;
    else
      state <= state_next;
  end

  // Next state, strobes and counter controls. Reset low overrides all of it
  // so a mid-vector reset drops the strobes in the same cycle.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    wr_en_x    = 1'b0;
    en_acc     = 1'b0;
    clear_acc  = 1'b0;
    x_en = 1'b0; x_clr = 1'b0;
    w_en = 1'b0; w_clr = 1'b0;
    g_en = 1'b0; g_clr = 1'b0;
    d_en = 1'b0; d_clr = 1'b0;
    o_en = 1'b0; o_clr = 1'b0;

    case (state)
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_en_x = 1'b1;
          x_en    = 1'b1;
          if (x_wrap) begin
            state_next = COMPUTE;
            w_clr      = 1'b1;
            g_clr      = 1'b1;
          end
        end
      end
      COMPUTE: begin
        en_acc    = 1'b1;
        clear_acc = (xcnt == '0);
        x_en      = 1'b1;
        w_en      = 1'b1;
        if (x_wrap) begin
          state_next = DRAIN;
          d_clr      = 1'b1;
        end
      end
      DRAIN: begin
        d_en = 1'b1;
        if (d_wrap) begin
          state_next = OUTPUT;
          o_clr      = 1'b1;
        end
      end
      OUTPUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          o_en = 1'b1;
          if (o_wrap) begin
            if (g_wrap) begin
              state_next = LOAD;
              w_clr      = 1'b1;
              g_clr      = 1'b1;
            end else begin
              g_en       = 1'b1;
              state_next = COMPUTE;
            end
          end
        end
      end
      default: state_next = LOAD;
    endcase

    if (!reset) begin
      state_next = LOAD;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      wr_en_x    = 1'b0;
      en_acc     = 1'b0;
      clear_acc  = 1'b0;
      x_en = 1'b0; w_en = 1'b0; g_en = 1'b0; d_en = 1'b0; o_en = 1'b0;
      x_clr = 1'b1; w_clr = 1'b1; g_clr = 1'b1; d_clr = 1'b1; o_clr = 1'b1;
    end
  end

  // Addresses follow their counters; held at zero while in reset so the
  // datapath never sees stale counter values.
  assign addr_x  = reset ? xcnt : '0;
  assign addr_w  = reset ? wcnt : '0;
  assign out_sel = reset ? ocnt : '0;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Directed bench for fc_layer_ctrl with M=4, N=8, P=2, MACLAT=2.
module tb_fc_layer_ctrl;

  localparam int M = 4, N = 8, P = 2, MACLAT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic       s_ready, m_valid, wr_en_x, clear_acc, en_acc;
  logic [1:0] addr_x;
  logic [3:0] addr_w;
  logic [0:0] out_sel;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  fc_layer_ctrl #(.M(M), .N(N), .P(P), .MACLAT(MACLAT)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .m_ready(m_ready), .m_valid(m_valid), .wr_en_x(wr_en_x),
    .addr_x(addr_x), .addr_w(addr_w), .clear_acc(clear_acc),
    .en_acc(en_acc), .out_sel(out_sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed compare: {s_ready,m_valid,wr_en_x,en_acc,clear_acc,addr_x,addr_w,out_sel}
  task automatic expect_o(input string tag, input bit sr, input bit mv, input bit we,
                          input bit ea, input bit ca, input int ax, input int aw, input int os);
    logic [1:0] eax;
    logic [3:0] eaw;
    logic [0:0] eos;
    eax = ax[1:0];
    eaw = aw[3:0];
    eos = os[0:0];
    chk(tag, {20'b0, s_ready, m_valid, wr_en_x, en_acc, clear_acc, addr_x, addr_w, out_sel},
             {20'b0, sr, mv, we, ea, ca, eax, eaw, eos});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four back-to-back input beats with s_valid held high.
  task automatic load_vec(input string tag);
    for (int k = 0; k < M; k++) begin
      expect_o($sformatf("%s_load%0d", tag, k), 1, 0, 1, 0, 0, k, 0, 0);
      tick();
    end
  endtask

  // One output group: M compute steps, MACLAT drain cycles, P output beats.
  task automatic run_group(input string tag, input int g, input bit hold);
    int aw_o;
    for (int k = 0; k < M; k++) begin
      expect_o($sformatf("%s_g%0d_cmp%0d", tag, g, k), 0, 0, 0, 1, (k == 0), k, g * M + k, 0);
      tick();
    end
    aw_o = (g * M + M) % 16;
    for (int d = 0; d < MACLAT; d++) begin
      expect_o($sformatf("%s_g%0d_drn%0d", tag, g, d), 0, 0, 0, 0, 0, 0, aw_o, 0);
      tick();
    end
    if (hold) begin
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
        expect_o($sformatf("%s_g%0d_hold%0d", tag, g, i), 0, 1, 0, 0, 0, 0, aw_o, 0);
        tick();
      end
      m_ready = 1'b1;
    end
    for (int o = 0; o < P; o++) begin
      expect_o($sformatf("%s_g%0d_out%0d", tag, g, o), 0, 1, 0, 0, 0, 0, aw_o, o);
      tick();
    end
  endtask

  initial begin
    int start, beats, pulses, guard;

    // Reset held with s_valid high: every strobe and address stays 0.
    reset = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    tick();
    tick();
    expect_o("reset_state", 0, 0, 0, 0, 0, 0, 0, 0);

    // Vector 1: zero-stall sequence.
    reset = 1'b1;
    #1;
    start = cyc;
    load_vec("v1");
    for (int g = 0; g < N / P; g++) run_group("v1", g, 1'b0);
    chk("v1_cycles", 32'(cyc - start), 32'd36);
    expect_o("v1_sready_back", 1, 0, 1, 0, 0, 0, 0, 0);

    // Vector 2 back to back, with downstream stall in group 0 output.
    load_vec("v2");
    run_group("v2", 0, 1'b1);
    for (int g = 1; g < N / P; g++) run_group("v2", g, 1'b0);

    // Vector 3: random s_valid, address advances only on accepted beats.
    beats = 0; pulses = 0; guard = 0;
    while (beats < M && guard < 200) begin
      s_valid = 1'($urandom_range(0, 1));
      #1;
      expect_o($sformatf("v3_rnd%0d", guard), 1, 0, s_valid, 0, 0, beats, 0, 0);
      if (wr_en_x) pulses++;
      if (s_valid) beats++;
      tick();
      guard++;
    end
    chk("v3_beats_in_budget", 32'(beats), 32'(M));
    chk("v3_wr_pulses", 32'(pulses), 32'(M));
    s_valid = 1'b1;
    run_group("v3", 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      expect_o($sformatf("v3_g1_cmp%0d", k), 0, 0, 0, 1, (k == 0), k, M + k, 0);
      if (k < 2) tick();
    end

    // Reset at xcnt=2 of group 1: strobes drop at once, then clean LOAD.
    reset = 1'b0; s_valid = 1'b0;
    #1;
    expect_o("midrst_low", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    #1;
    expect_o("midrst_load", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_o($sformatf("midrst_idle%0d", i), 1, 0, 0, 0, 0, 0, 0, 0);
    end

    // Vector 4 after abort starts from scratch: addr_w 0 with clear_acc.
    s_valid = 1'b1;
    #1;
    load_vec("v4");
    run_group("v4", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_layer_ctrl.md
# fc_layer_ctrl

Sequencing controller for one fully-connected layer of a chained network datapath. Accepts an M-element input vector over a valid/ready stream into the layer's input memory, then walks N/P output groups. For each group it issues M address/accumulate steps to P parallel MACs, waits for the MAC pipeline to drain, and streams the P results out. One instance sits beside each layer's datapath (input memory, weight ROM, P MACs, output mux) and owns all of its handshakes.

## Interface
Parameters:
- M, 4, input vector length (M >= 2)
- N, 8, output vector length (N % P == 0 required)
- P, 2, MACs working in parallel
- MACLAT, 2, cycles from last en_acc issue until the accumulator value is stable at the mux

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low (0 = reset), sampled on rising edge of clk
- s_valid  in  1  upstream data valid
- s_ready  out  1  controller can accept an input beat
- m_ready  in  1  downstream ready
- m_valid  out  1  data_out of datapath is valid
- wr_en_x  out  1  input-memory write strobe
- addr_x  out  $clog2(M)  input-memory address (write in LOAD, read in COMPUTE)
- addr_w  out  $clog2(M*N/P)  weight-ROM address
- clear_acc  out  1  zero the accumulators on this step
- en_acc  out  1  accumulate this step
- out_sel  out  $clog2(P)  output mux select

## Operation
- States: LOAD, COMPUTE, DRAIN, OUTPUT.
- Counters: xcnt (0..M-1), wcnt (0..M*N/P-1), grp (0..N/P-1), dcnt (0..MACLAT-1), ocnt (0..P-1).
- LOAD:
  - s_ready=1.
  - wr_en_x = s_valid & s_ready; addr_x = xcnt.
  - On each accepted beat, xcnt++.
  - Accepted beat with xcnt==M-1: go to COMPUTE; xcnt=0, wcnt=0, grp=0.
- COMPUTE:
  - en_acc=1 every cycle; addr_x=xcnt; addr_w=wcnt; clear_acc=1 only when xcnt==0.
  - xcnt++ and wcnt++ every cycle. There is no stall.
  - When xcnt==M-1: go to DRAIN; dcnt=0, xcnt=0.
- DRAIN:
  - No strobes asserted; dcnt++.
  - When dcnt==MACLAT-1: go to OUTPUT; ocnt=0.
- OUTPUT:
  - m_valid=1; out_sel=ocnt.
  - On m_valid & m_ready, ocnt++.
  - Last accepted beat (ocnt==P-1): if grp==N/P-1, go to LOAD with wcnt=0; else grp++ and go to COMPUTE. wcnt continues, so addr_w = grp*M + xcnt.
- Outside their states, s_ready, m_valid, wr_en_x, en_acc and clear_acc are 0. Address and select outputs hold their counter values.
- Read-latency alignment of en_acc/clear_acc against memory data is the datapath's job. The controller emits address and strobe in the same cycle.

## Timing
- Reset (reset==0 at an edge):
  - Next state is LOAD; all counters 0.
  - While reset is low, s_ready, m_valid, wr_en_x, en_acc and clear_acc are forced 0 combinationally.
  - addr_x=0, addr_w=0, out_sel=0.
- Reset mid-operation aborts the vector immediately. Partial accumulations are discarded and no m_valid follows.
- Handshakes:
  - s_ready and m_valid depend only on state and reset, never on s_valid or m_ready.
  - Once m_valid is raised, it and out_sel hold until the beat is accepted.
- Zero-stall cycle count per vector: M + (N/P)·(M + MACLAT + P).
- The first s_ready after the last output beat is the next cycle; there is no bubble.
- In LOAD, s_valid=0 holds all counters. In OUTPUT, m_ready=0 holds all counters.

## Structure
- Shared package fc_ctrl_pkg holds:
  - typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, OUTPUT} fc_state_t;
  - function clog2_min1(n), returning width max(1, $clog2(n)).
- One sub-module, mod_counter: parameterized modulus, with en, clr and wrap flag outputs. It is instantiated for xcnt, wcnt, grp, dcnt and ocnt.
- State register and next-state logic live in fc_layer_ctrl.

## Test plan
All scenarios use M=4, N=8, P=2, MACLAT=2.
- Release reset, then s_valid=1 and m_ready=1 constantly:
  - wr_en_x with addr_x 0,1,2,3.
  - Then group 0 on addr_w 0–3, clear_acc only on the first step, then 2 idle cycles, then m_valid for 2 cycles with out_sel 0,1.
  - Groups 1–3 on addr_w 4–7, 8–11, 12–15.
  - s_ready returns 36 cycles after the first accepted beat.
- Hold m_ready=0 for 10 cycles in OUTPUT of group 0: m_valid stays 1, out_sel stays 0, no counter changes. On release, it proceeds normally.
- Randomize s_valid (about 50%): addr_x advances only on accepted beats, and exactly 4 wr_en_x pulses occur before COMPUTE.
- Assert reset in COMPUTE at step xcnt=2 of group 1: next cycle all strobes are 0, addr_w=0, state is LOAD, and no m_valid appears before 4 new beats arrive.
- Two vectors back to back: the second vector's first COMPUTE starts at addr_w=0 with clear_acc=1.
- Integrate with the layer datapath under the random valid/ready stream bench. For 1000 random vectors, every output matches the golden expected file with zero errors.
